clk_period_meter: RTL and testbench

- Receive end of the divided-clock path: takes a slow toggling signal from a clock divider and measures its half-period in system clk cycles.
- Reports the equivalent divider terminal count `est_max`, a per-edge valid pulse, a lock flag and a timeout flag.
- Used by game logic to confirm that the tempo clock runs at the programmed rate and to detect a stopped or paused tempo.

---
 rtl/clk_meter_pkg.sv | 9 +
 rtl/clk_period_meter_edge_sync.sv | 16 +
 rtl/clk_period_meter.sv | 92 +++++++++
 tb/tb_clk_period_meter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// clk_meter_pkg: shared state encoding and default widths for clk_period_meter
package clk_meter_pkg;
  localparam int DEF_CNT_W = 27;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2
  } state_t;
endpackage

// File: rtl/clk_period_meter_edge_sync.sv
// edge_sync: two-flop synchroniser plus history flop, flags either edge of din
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic din,
  output logic edge_det
);
  logic s1, s2, s3;
  // Shift din through the synchroniser and keep one cycle of history
  always_ff @(posedge clk or posedge reset)
    if (reset) {s1, s2, s3} <= '0;
    else if (clear) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {din, s1, s2};
  assign edge_det = s2 ^ s3;
endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures slow_in half-period in clk cycles; JITTER_TOL_EN enables +/-JITTER_TOL matching
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT_MAX = 2**27-1,
  parameter int JITTER_TOL  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             slow_in,
  output logic [CNT_W-1:0] est_max,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout,
  output logic [1:0]       state
);
`ifdef JITTER_TOL_EN
  localparam bit JIT_EN = 1'b1;
`else
  localparam bit JIT_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT_MAX);
  localparam logic [CNT_W:0]   TOL  = (CNT_W+1)'(JIT_EN ? JITTER_TOL : 0);
  localparam logic [3:0]       LC   = 4'(LOCK_COUNT);
  state_t           st, st_n;
  logic             edge_det, match, mv_n, lk_n, to_n;
  logic [CNT_W-1:0] cnt, cnt_n, est_n;
  logic [CNT_W:0]   diff, adiff;
  logic [3:0]       mc, mc_n, mc_inc;
  edge_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .din      (slow_in),
    .edge_det (edge_det)
  );
  assign diff   = {1'b0, cnt} - {1'b0, est_max};
  assign adiff  = diff[CNT_W] ? -diff : diff;
  assign match  = adiff <= TOL;
  assign mc_inc = (mc >= LC) ? LC : mc + 4'd1;
  assign state  = st;
  // Next-state, measurement and lock/timeout decisions; an edge always beats a timeout
  always_comb begin
    st_n  = st;
    cnt_n = (cnt == TMAX) ? TMAX : cnt + CNT_W'(1);
    est_n = est_max;
    mc_n  = mc;
    mv_n  = 1'b0;
    lk_n  = locked;
    to_n  = 1'b0;
    if (edge_det) begin
      cnt_n = '0;
      if (st == ST_IDLE) st_n = ST_ACQ;
      else begin
        est_n = cnt;
        mv_n  = 1'b1;
        st_n  = ST_TRACK;
        mc_n  = (st == ST_TRACK && match) ? mc_inc : 4'd0;
        lk_n  = (st == ST_TRACK) ? (match && mc_inc == LC) : locked;
      end
    end else if (st == ST_IDLE) cnt_n = '0;
    else if (cnt == TMAX) begin
      to_n  = 1'b1;
      lk_n  = 1'b0;
      mc_n  = 4'd0;
      st_n  = ST_IDLE;
      cnt_n = '0;
    end
  end
  // State and output registers
  always_ff @(posedge clk or posedge reset)
    if (reset || clear) begin
      st         <= ST_IDLE;
      cnt        <= '0;
      est_max    <= '0;
      mc         <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      st         <= st_n;
      cnt        <= cnt_n;
      est_max    <= est_n;
      mc         <= mc_n;
      meas_valid <= mv_n;
      locked     <= lk_n;
      timeout    <= to_n;
    end
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed tests of measurement, lock, timeout, reset and clear
module tb_clk_period_meter;
  import clk_meter_pkg::*;
  logic        clk = 1'b0;
  logic        reset, clear, slow_in;
  logic [26:0] est_max;
  logic        meas_valid, locked, timeout;
  logic [1:0]  state;
  int          checks = 0;
  int          errors = 0;
  int          meas_n, to_n;
  logic [26:0] est_log [64];
  logic        lk_log  [64];
  int          cyc_log [64];

  clk_period_meter #(.CNT_W(27), .LOCK_COUNT(4), .TIMEOUT_MAX(100), .JITTER_TOL(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .slow_in    (slow_in),
    .est_max    (est_max),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout),
    .state      (state)
  );

  always #5 clk = ~clk;

  task clr_log;
    meas_n = 0;
    to_n   = 0;
  endtask

  task observe(input int k);
    @(negedge clk);
    if (meas_valid && meas_n < 63) begin
      meas_n++;
      est_log[meas_n] = est_max;
      lk_log[meas_n]  = locked;
      cyc_log[meas_n] = k;
    end
    if (timeout) to_n++;
  endtask

  task toggle_run(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      slow_in = ~slow_in;
      for (int k = 1; k <= p; k++) observe(k);
    end
  endtask

  task test_reset;
    reset = 1'b1; clear = 1'b0; slow_in = 1'b0;
    @(negedge clk);
    checks++;
    if ({est_max, meas_valid, locked, timeout, state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got est=%0d mv=%b lk=%b to=%b st=%0d expected all zero", est_max, meas_valid, locked, timeout, state);
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) observe(0);
  endtask

  task test_lock;
    logic bad;
    clr_log;
    toggle_run(5, 7);
    bad = 1'b0;
    for (int m = 1; m <= meas_n; m++) if (est_log[m] !== 27'd4) bad = 1'b1;
    checks++; if (meas_n != 6) begin errors++; $display("FAIL lock_meas_count: got %0d expected 6", meas_n); end
    checks++; if (est_log[1] !== 27'd4) begin errors++; $display("FAIL lock_first_est: got %0d expected 4", est_log[1]); end
    checks++; if (bad) begin errors++; $display("FAIL lock_all_est: some est_max differs from 4"); end
    checks++; if (cyc_log[1] != 3) begin errors++; $display("FAIL lock_latency: got %0d expected 3", cyc_log[1]); end
    checks++; if (lk_log[4] !== 1'b0) begin errors++; $display("FAIL lock_early: got %b expected 0", lk_log[4]); end
    checks++; if (lk_log[5] !== 1'b1) begin errors++; $display("FAIL lock_at_5: got %b expected 1", lk_log[5]); end
    checks++; if (to_n != 0) begin errors++; $display("FAIL lock_no_timeout: got %0d expected 0", to_n); end
    checks++; if (state !== ST_TRACK) begin errors++; $display("FAIL lock_state: got %0d expected 2", state); end
  endtask

  task test_period_change;
    clr_log;
    toggle_run(8, 6);
    checks++; if (meas_n != 6) begin errors++; $display("FAIL chg_meas_count: got %0d expected 6", meas_n); end
    checks++; if (lk_log[1] !== 1'b1) begin errors++; $display("FAIL chg_still_locked: got %b expected 1", lk_log[1]); end
    checks++; if (est_log[2] !== 27'd7) begin errors++; $display("FAIL chg_est: got %0d expected 7", est_log[2]); end
    checks++; if (lk_log[2] !== 1'b0) begin errors++; $display("FAIL chg_unlock: got %b expected 0", lk_log[2]); end
    checks++; if (lk_log[5] !== 1'b0) begin errors++; $display("FAIL chg_relock_early: got %b expected 0", lk_log[5]); end
    checks++; if (lk_log[6] !== 1'b1) begin errors++; $display("FAIL chg_relock: got %b expected 1", lk_log[6]); end
  endtask

  task test_timeout;
    int to_at;
    clr_log;
    toggle_run(5, 7);
    checks++; if (lk_log[7] !== 1'b1) begin errors++; $display("FAIL to_prelock: got %b expected 1", lk_log[7]); end
    to_at = 0;
    for (int k = 6; k <= 200; k++) begin
      observe(k);
      if (timeout && to_at == 0) to_at = k;
    end
    checks++; if (to_at != 104) begin errors++; $display("FAIL to_cycle: got %0d expected 104", to_at); end
    checks++; if (to_n != 1) begin errors++; $display("FAIL to_count: got %0d expected 1", to_n); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL to_locked: got %b expected 0", locked); end
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL to_state: got %0d expected 0", state); end
    checks++; if (est_max !== 27'd4) begin errors++; $display("FAIL to_est_held: got %0d expected 4", est_max); end
  endtask

  task test_edge_at_timeout;
    clr_log;
    toggle_run(101, 3);
    checks++; if (meas_n != 2) begin errors++; $display("FAIL edge_to_meas_count: got %0d expected 2", meas_n); end
    checks++; if (est_log[1] !== 27'd100) begin errors++; $display("FAIL edge_to_est1: got %0d expected 100", est_log[1]); end
    checks++; if (est_log[2] !== 27'd100) begin errors++; $display("FAIL edge_to_est2: got %0d expected 100", est_log[2]); end
    checks++; if (to_n != 0) begin errors++; $display("FAIL edge_to_timeout: got %0d expected 0", to_n); end
  endtask

  task test_async_reset;
    clr_log;
    toggle_run(5, 7);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL ar_prelock: got %b expected 1", locked); end
    #2;
    reset = 1'b1; slow_in = 1'b0;
    #1;
    checks++;
    if ({est_max, meas_valid, locked, timeout, state} !== '0) begin
      errors++;
      $display("FAIL ar_immediate: got est=%0d mv=%b lk=%b to=%b st=%0d expected all zero", est_max, meas_valid, locked, timeout, state);
    end
    @(negedge clk);
    reset = 1'b0;
    clr_log;
    toggle_run(5, 2);
    checks++; if (meas_n != 1) begin errors++; $display("FAIL ar_meas_count: got %0d expected 1", meas_n); end
    checks++; if (est_log[1] !== 27'd4) begin errors++; $display("FAIL ar_est: got %0d expected 4", est_log[1]); end
  endtask

  task test_clear;
    clr_log;
    toggle_run(5, 5);
    clear = 1'b1; slow_in = 1'b0;
    #1;
    checks++; if (state !== ST_TRACK) begin errors++; $display("FAIL clr_not_async: got %0d expected 2", state); end
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if ({est_max, meas_valid, locked, timeout, state} !== '0) begin
      errors++;
      $display("FAIL clr_outputs: got est=%0d mv=%b lk=%b to=%b st=%0d expected all zero", est_max, meas_valid, locked, timeout, state);
    end
    clr_log;
    toggle_run(5, 2);
    checks++; if (meas_n != 1) begin errors++; $display("FAIL clr_meas_count: got %0d expected 1", meas_n); end
    checks++; if (est_log[1] !== 27'd4) begin errors++; $display("FAIL clr_est: got %0d expected 4", est_log[1]); end
  endtask

  task test_jitter;
    int first_lk, exp_lk;
`ifdef JITTER_TOL_EN
    exp_lk = 5;
`else
    exp_lk = 0;
`endif
    reset = 1'b1; slow_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clr_log;
    for (int i = 0; i < 6; i++) begin
      toggle_run(5, 1);
      toggle_run(6, 1);
    end
    first_lk = 0;
    for (int m = 1; m <= meas_n; m++) if (lk_log[m] === 1'b1 && first_lk == 0) first_lk = m;
    checks++; if (meas_n != 11) begin errors++; $display("FAIL jit_meas_count: got %0d expected 11", meas_n); end
    checks++; if (est_log[2] !== 27'd5) begin errors++; $display("FAIL jit_est: got %0d expected 5", est_log[2]); end
    checks++; if (first_lk != exp_lk) begin errors++; $display("FAIL jit_lock_at: got %0d expected %0d", first_lk, exp_lk); end
  endtask

  initial begin
    test_reset;
    test_lock;
    test_period_change;
    test_timeout;
    test_edge_at_timeout;
    test_async_reset;
    test_clear;
    test_jitter;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
